collision_monitor: RTL and testbench

- Sits downstream of the game control unit.
- Consumes the dino and hurdle bounding boxes plus the VGA scan counters.
- Detects pixel-level overlap per frame and runs the game-state FSM (IDLE/RUN/HIT/OVER).
- Drives break_game back to the object movers (dino, hurdle, score) to freeze play on a crash.

---
 rtl/collision_monitor_pkg.sv | 18 +
 rtl/collision_monitor_box_hit.sv | 17 +
 rtl/collision_monitor.sv | 172 +++++++++++++++++
 tb/tb_collision_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_monitor_pkg.sv
// Shared definitions for the game collision monitor, sync generator and renderer.
package collision_monitor_pkg;

  localparam int COORD_W = 12;

  localparam int VGA_H_TOTAL  = 1040;
  localparam int VGA_V_TOTAL  = 666;
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_V_ACTIVE = 600;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

endpackage

// File: rtl/collision_monitor_box_hit.sv
// Inclusive point-in-rectangle test; a box whose From exceeds its To never matches.
module box_hit
  import collision_monitor_pkg::*;
(
  input  logic [COORD_W-1:0] hor_pos_i,
  input  logic [COORD_W-1:0] ver_pos_i,
  input  logic [COORD_W-1:0] hor_from_i,
  input  logic [COORD_W-1:0] hor_to_i,
  input  logic [COORD_W-1:0] ver_from_i,
  input  logic [COORD_W-1:0] ver_to_i,
  output logic               hit_o
);

  assign hit_o = (hor_pos_i >= hor_from_i) && (hor_pos_i <= hor_to_i) &&
                 (ver_pos_i >= ver_from_i) && (ver_pos_i <= ver_to_i);

endmodule

// File: rtl/collision_monitor.sv
// Per-pixel dino/hurdle overlap detection, per-frame hit accumulation and game-state FSM.
//   state | meaning
//   IDLE  | waiting for first space press, play frozen
//   RUN   | game running, no overlap in the previous frame
//   HIT   | overlap seen in consecutive frames, not yet enough to end the game
//   OVER  | crash declared, play frozen, restart allowed after the hold period
module collision_monitor
  import collision_monitor_pkg::*;
#(
  parameter int H_TOTAL    = VGA_H_TOTAL,
  parameter int V_TOTAL    = VGA_V_TOTAL,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int HIT_FRAMES = 2,
  parameter int OVER_HOLD  = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        hor_reg,
  input  logic [9:0]         ver_reg,
  input  logic [COORD_W-1:0] DinoPosHorFrom,
  input  logic [COORD_W-1:0] DinoPosHorTo,
  input  logic [COORD_W-1:0] DinoPosVerFrom,
  input  logic [COORD_W-1:0] DinoPosVerTo,
  input  logic [COORD_W-1:0] hudPosHorFrom,
  input  logic [COORD_W-1:0] hudPosHorTo,
  input  logic [COORD_W-1:0] hudPosVerFrom,
  input  logic [COORD_W-1:0] hudPosVerTo,
  input  logic               Spaceflag,
  output logic               break_game,
  output logic [1:0]         game_state,
  output logic               collision_pix,
  output logic               frame_tick
);

  localparam int HIT_W  = $clog2(HIT_FRAMES + 1);
  localparam int HOLD_W = $clog2(OVER_HOLD + 1);

  localparam logic [HIT_W-1:0]  HIT_LAST = HIT_W'(HIT_FRAMES - 1);
  localparam logic [HIT_W-1:0]  HIT_ONE  = HIT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD);
  localparam logic [10:0]       H_END    = 11'(H_TOTAL - 1);
  localparam logic [9:0]        V_END    = 10'(V_TOTAL - 1);
  localparam logic [10:0]       H_ACT    = 11'(H_ACTIVE);
  localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);

  logic [COORD_W-1:0] hor_pos, ver_pos;
  logic               in_dino, in_hud, active_area, end_pos;
  logic               frame_hit, space_rise;

  logic               coll_q, coll_d;
  logic               acc_q, acc_d;
  logic               tick_q, tick_d;
  logic               sp_q, sp_d;
  logic               brk_q, brk_d;
  game_state_e        state_q, state_d;
  logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  assign hor_pos = COORD_W'(hor_reg);
  assign ver_pos = COORD_W'(ver_reg);

  box_hit u_dino_hit (
    .hor_pos_i  (hor_pos),
    .ver_pos_i  (ver_pos),
    .hor_from_i (DinoPosHorFrom),
    .hor_to_i   (DinoPosHorTo),
    .ver_from_i (DinoPosVerFrom),
    .ver_to_i   (DinoPosVerTo),
    .hit_o      (in_dino)
  );

  box_hit u_hud_hit (
    .hor_pos_i  (hor_pos),
    .ver_pos_i  (ver_pos),
    .hor_from_i (hudPosHorFrom),
    .hor_to_i   (hudPosHorTo),
    .ver_from_i (hudPosVerFrom),
    .ver_to_i   (hudPosVerTo),
    .hit_o      (in_hud)
  );

  assign active_area = (hor_reg < H_ACT) && (ver_reg < V_ACT);
  assign end_pos     = (hor_reg == H_END) && (ver_reg == V_END);

  assign coll_d     = active_area & in_dino & in_hud;
  assign tick_d     = end_pos;
  assign sp_d       = Spaceflag;
  assign space_rise = Spaceflag & ~sp_q;
  // The pixel registered in the tick cycle still counts for the frame being closed.
  assign frame_hit  = acc_q | coll_q;
  assign acc_d      = tick_q ? 1'b0 : (acc_q | coll_q);

  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (space_rise) begin
          state_d    = ST_RUN;
          hit_cnt_d  = '0;
          hold_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (tick_q && frame_hit) begin
          if (HIT_FRAMES == 1) begin
            state_d    = ST_OVER;
            hold_cnt_d = '0;
          end else begin
            state_d   = ST_HIT;
            hit_cnt_d = HIT_ONE;
          end
        end
      end
      ST_HIT: begin
        if (tick_q) begin
          if (!frame_hit) begin
            state_d   = ST_RUN;
            hit_cnt_d = '0;
          end else if (hit_cnt_q == HIT_LAST) begin
            state_d    = ST_OVER;
            hold_cnt_d = '0;
          end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end
      end
      ST_OVER: begin
        // Restart check uses the pre-increment hold count when a tick coincides.
        if (space_rise && (hold_cnt_q == HOLD_MAX)) begin
          state_d    = ST_RUN;
          hit_cnt_d  = '0;
          hold_cnt_d = '0;
        end else if (tick_q && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    brk_d = (state_d == ST_OVER) || (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q     <= 1'b0;
      acc_q      <= 1'b0;
      tick_q     <= 1'b0;
      sp_q       <= 1'b0;
      brk_q      <= 1'b1;
      state_q    <= ST_IDLE;
      hit_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      coll_q     <= coll_d;
      acc_q      <= acc_d;
      tick_q     <= tick_d;
      sp_q       <= sp_d;
      brk_q      <= brk_d;
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign break_game    = brk_q;
  assign game_state    = state_q;
  assign collision_pix = coll_q;
  assign frame_tick    = tick_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Frame-level scoreboard bench for collision_monitor on a shrunken scan raster.
module tb_collision_monitor;

  localparam int HT = 32;
  localparam int VT = 16;
  localparam int HA = 24;
  localparam int VA = 12;
  localparam int HF = 2;
  localparam int OH = 3;
  localparam int FRAME = HT * VT;
  localparam int S_IDLE = 0, S_RUN = 1, S_HIT = 2, S_OVER = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hor_reg = '0;
  logic [9:0]  ver_reg = '0;
  logic [11:0] DinoPosHorFrom = '0, DinoPosHorTo = '0, DinoPosVerFrom = '0, DinoPosVerTo = '0;
  logic [11:0] hudPosHorFrom = '0, hudPosHorTo = '0, hudPosVerFrom = '0, hudPosVerTo = '0;
  logic        Spaceflag = 1'b0;
  logic        break_game, collision_pix, frame_tick;
  logic [1:0]  game_state;

  collision_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .HIT_FRAMES(HF), .OVER_HOLD(OH)
  ) dut (
    .clk(clk), .rst(rst), .hor_reg(hor_reg), .ver_reg(ver_reg),
    .DinoPosHorFrom(DinoPosHorFrom), .DinoPosHorTo(DinoPosHorTo),
    .DinoPosVerFrom(DinoPosVerFrom), .DinoPosVerTo(DinoPosVerTo),
    .hudPosHorFrom(hudPosHorFrom), .hudPosHorTo(hudPosHorTo),
    .hudPosVerFrom(hudPosVerFrom), .hudPosVerTo(hudPosVerTo),
    .Spaceflag(Spaceflag), .break_game(break_game), .game_state(game_state),
    .collision_pix(collision_pix), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // mode: 0 space low, 1 short press mid-frame, 2 short press from the first cycle, 3 held all frame
  typedef struct {
    int mode;
    int dhf, dht, dvf, dvt;
    int hhf, hht, hvf, hvt;
  } frame_t;

  typedef struct {
    int n;
    int st;
  } exp_t;

  frame_t frames[$];
  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     m_state, m_hit, m_hold;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic frame_t mk(input int mode, input int dhf, input int dht, input int dvf,
                                input int dvt, input int hhf, input int hht, input int hvf,
                                input int hvt);
    frame_t f;
    f.mode = mode;
    f.dhf = dhf; f.dht = dht; f.dvf = dvf; f.dvt = dvt;
    f.hhf = hhf; f.hht = hht; f.hvf = hvf; f.hvt = hvt;
    return f;
  endfunction

  // Number of visible coordinates shared by two inclusive ranges.
  function automatic int span(input int a0, input int a1, input int b0, input int b1, input int lim);
    int lo, hi;
    lo = (a0 > b0) ? a0 : b0;
    hi = (a1 < b1) ? a1 : b1;
    if (hi > lim - 1) hi = lim - 1;
    return (hi >= lo) ? (hi - lo + 1) : 0;
  endfunction

  function automatic int overlap(input frame_t f);
    return span(f.dhf, f.dht, f.hhf, f.hht, HA) * span(f.dvf, f.dvt, f.hvf, f.hvt, VA);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_hit = 0; m_hold = 0;
  endtask

  task automatic model_space();
    if (m_state == S_IDLE || (m_state == S_OVER && m_hold == OH)) begin
      m_state = S_RUN; m_hit = 0; m_hold = 0;
    end
  endtask

  task automatic model_tick(input bit hit);
    case (m_state)
      S_RUN: if (hit) begin
        if (HF == 1) begin m_state = S_OVER; m_hold = 0; end
        else begin m_state = S_HIT; m_hit = 1; end
      end
      S_HIT: begin
        if (!hit) begin m_state = S_RUN; m_hit = 0; end
        else if (m_hit == HF - 1) begin m_state = S_OVER; m_hold = 0; end
        else m_hit++;
      end
      S_OVER: if (m_hold < OH) m_hold++;
      default: ;
    endcase
  endtask

  task automatic set_pixel(input frame_t f, input int h, input int v);
    int idx;
    idx = v * HT + h;
    hor_reg = 11'(h); ver_reg = 10'(v);
    DinoPosHorFrom = 12'(f.dhf); DinoPosHorTo = 12'(f.dht);
    DinoPosVerFrom = 12'(f.dvf); DinoPosVerTo = 12'(f.dvt);
    hudPosHorFrom  = 12'(f.hhf); hudPosHorTo  = 12'(f.hht);
    hudPosVerFrom  = 12'(f.hvf); hudPosVerTo  = 12'(f.hvt);
    case (f.mode)
      1: Spaceflag = (idx >= 100 && idx < 104);
      2: Spaceflag = (idx < 4);
      3: Spaceflag = 1'b1;
      default: Spaceflag = 1'b0;
    endcase
  endtask

  task automatic drive_frame(input frame_t f);
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        set_pixel(f, h, v);
        @(posedge clk); #1;
      end
  endtask

  // A press in the first cycle of the next frame lands on this frame's tick.
  task automatic run_frames();
    frame_t f;
    exp_t   e;
    bit     sim_rise;
    for (int k = 0; k < frames.size(); k++) begin
      f = frames[k];
      if (f.mode == 1) model_space();
      e.n = overlap(f);
      sim_rise = (k + 1 < frames.size()) && (f.mode != 3) &&
                 (frames[k + 1].mode == 2 || frames[k + 1].mode == 3);
      if (sim_rise && (m_state == S_IDLE || (m_state == S_OVER && m_hold == OH))) model_space();
      else model_tick(e.n > 0);
      e.st = m_state;
      exp_q.push_back(e);
      drive_frame(f);
    end
  endtask

  int mon_cnt = 0, mon_cyc = 0, mon_exp_st = 0;
  bit mon_prev = 1'b0, mon_pend = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      mon_cnt = 0; mon_cyc = 0; mon_prev = 1'b0; mon_pend = 1'b0;
    end else begin
      if (mon_pend) begin
        check("game_state", int'(game_state), mon_exp_st);
        check("break_game", int'(break_game), int'(mon_exp_st == S_IDLE || mon_exp_st == S_OVER));
        mon_pend = 1'b0;
      end
      mon_cnt += int'(collision_pix);
      mon_cyc++;
      if (frame_tick) begin
        if (mon_prev) check("tick_period", mon_cyc, FRAME);
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("coll_count", mon_cnt, mon_e.n);
          mon_exp_st = mon_e.st;
          mon_pend = 1'b1;
        end
        mon_prev = 1'b1;
        mon_cnt = 0;
        mon_cyc = 0;
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected frames pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t clr, ovl, f;
    int r, md;
    clr = mk(0, 4, 8, 2, 6, 14, 16, 3, 6);
    ovl = mk(0, 4, 8, 2, 6, 7, 10, 3, 6);

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(game_state), S_IDLE);
    check("rst_break", int'(break_game), 1);
    check("rst_coll", int'(collision_pix), 0);
    check("rst_tick", int'(frame_tick), 0);
    rst = 1'b0;

    // Directed sequence: start, double-hit to OVER, hold period, single hit recovery,
    // press on the tick just before the hold expires, held key, inverted hurdle box.
    frames.push_back(clr);
    f = clr; f.mode = 1; frames.push_back(f);
    frames.push_back(ovl);
    frames.push_back(ovl);
    frames.push_back(f);
    frames.push_back(clr);
    frames.push_back(clr);
    frames.push_back(f);
    frames.push_back(ovl);
    frames.push_back(clr);
    frames.push_back(ovl);
    frames.push_back(ovl);
    frames.push_back(clr);
    frames.push_back(clr);
    frames.push_back(clr);
    f = clr; f.mode = 3;
    frames.push_back(f);
    frames.push_back(f);
    frames.push_back(f);
    frames.push_back(clr);
    f = clr; f.mode = 1; frames.push_back(f);
    frames.push_back(mk(0, 8, 16, 2, 6, 20, 10, 3, 6));

    for (int i = 0; i < 50; i++) begin
      r  = $urandom_range(0, 9);
      md = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      f.mode = md;
      f.dhf = $urandom_range(0, 26); f.dht = f.dhf + $urandom_range(0, 8);
      f.dvf = $urandom_range(0, 12); f.dvt = f.dvf + $urandom_range(0, 6);
      f.hhf = $urandom_range(0, 30); f.hht = f.hhf + $urandom_range(0, 6);
      f.hvf = $urandom_range(0, 12); f.hvt = f.hvf + $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) begin r = f.hhf; f.hhf = f.hht + 1; f.hht = r; end
      if ($urandom_range(0, 9) == 0) begin r = f.hvf; f.hvf = f.hvt + 1; f.hvt = r; end
      frames.push_back(f);
    end

    model_reset();
    run_frames();

    for (int h = 0; h < 3; h++) begin
      set_pixel(clr, h, 0);
      @(posedge clk); #1;
    end
    check("queue_drained", exp_q.size(), 0);

    // Fresh start, reach HIT, then reset in the middle of an overlapping frame.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    frames.delete();
    model_reset();
    f = mk(1, 10, 20, 0, 8, 26, 28, 1, 5);
    frames.push_back(f);
    f = mk(0, 10, 20, 0, 8, 15, 25, 1, 5);
    frames.push_back(f);
    run_frames();
    for (int i = 0; i < 50; i++) begin
      set_pixel(f, i % HT, i / HT);
      @(posedge clk); #1;
    end
    check("pre_rst_coll", int'(collision_pix), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_state", int'(game_state), S_IDLE);
    check("midrst_break", int'(break_game), 1);
    check("midrst_coll", int'(collision_pix), 0);
    check("midrst_tick", int'(frame_tick), 0);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
